// File: rtl/pmod_als_spi_responder.sv
// SPI responder emulating the PMOD ALS (ADC081S021-style 16-bit read frame).
// Oversamples CS/SCLK in the system clock domain and shifts an 8-bit sample out MSB first.
module pmod_als_spi_responder #(
  parameter int DATA_W      = 8,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_100m_i,
  input  logic              rst,
  input  logic              cs_i,
  input  logic              sclk_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, settle_q;
  logic                   cs_prev_q, sclk_prev_q, arm_q;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shift_q, word_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   miso_q, oe_q, done_q, err_q, busy_q;

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample pre-edge values, independent of statement order.
  always_ff @(posedge clk_100m_i or negedge rst) begin
    if (!rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      settle_q    <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      // Only arm once CS has been seen high after the synchronizer refilled,
      // so a CS held low through reset cannot fake a falling edge.
      if (settle_q[SYNC_STAGES-1] && cs_s) arm_q <= 1'b1;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s & arm_q;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    word_d = '0;
    word_d[FRAME_BITS-1-LEAD_ZEROS -: DATA_W] = sample_i;
  end

  // Counter update is computed ahead of the CS-release check, so a final
  // rise coinciding with CS release still completes the frame.
  assign cnt_d = (sclk_rise && (cnt_q != FULL)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_100m_i or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= SHIFT;
            shift_q <= word_d;
            miso_q  <= word_d[FRAME_BITS-1];
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          if (cs_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            if (cnt_d == FULL) done_q <= 1'b1;
            else               err_q  <= 1'b1;
          end else if (sclk_fall && (cnt_q != '0)) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
            miso_q  <= (cnt_q == FULL) ? 1'b0 : shift_q[FRAME_BITS-2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso_o       = miso_q;
  assign miso_oe_o    = oe_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// Directed bench for pmod_als_spi_responder: acts as the ALS master, shifting
// MISO in on each SCLK rising edge and comparing against hand-computed frames.
module tb_pmod_als_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_i;
  logic       sclk_i;
  logic [7:0] sample_i;
  logic       miso_o, miso_oe_o, frame_done_o, frame_err_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic track_idle = 1'b0;
  logic idle_act = 1'b0;

  pmod_als_spi_responder dut (
    .clk_100m_i  (clk),
    .rst         (rst),
    .cs_i        (cs_i),
    .sclk_i      (sclk_i),
    .sample_i    (sample_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .frame_done_o(frame_done_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done_o) done_cnt++;
    if (frame_err_o)  err_cnt++;
    if (track_idle) idle_act = idle_act | miso_o | miso_oe_o | busy_o | frame_done_o | frame_err_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame: SCLK idles high, 1 MHz (50 clk low / 50 clk high),
  // MISO sampled just before each rising edge.
  task automatic run_frame(input logic [7:0] smp, input int nbits, input int change_at,
                           input logic [7:0] smp2, output logic [31:0] rx);
    rx = '0;
    sample_i = smp;
    cs_i = 1'b0;
    wait_clk(20);
    check("oe_active", 32'(miso_oe_o), 32'd1);
    check("busy_active", 32'(busy_o), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) sample_i = smp2;
      sclk_i = 1'b0;
      wait_clk(50);
      rx = {rx[30:0], miso_o};
      sclk_i = 1'b1;
      wait_clk(50);
    end
    cs_i = 1'b1;
    wait_clk(2);
    check("oe_hold_2cyc", 32'(miso_oe_o), 32'd1);
    wait_clk(1);
    check("oe_drop_3cyc", 32'(miso_oe_o), 32'd0);
    check("pulse_on", 32'(frame_done_o | frame_err_o), 32'd1);
    wait_clk(1);
    check("pulse_1cyc", 32'({frame_done_o, frame_err_o}), 32'd0);
    wait_clk(20);
  endtask

  logic [31:0] rx;
  int d0, e0;

  initial begin
    rst = 1'b0;
    cs_i = 1'b1;
    sclk_i = 1'b1;
    sample_i = 8'h00;
    wait_clk(5);
    check("reset_outs", 32'({miso_o, miso_oe_o, frame_done_o, frame_err_o, busy_o}), 32'd0);
    rst = 1'b1;
    wait_clk(20);
    check("post_reset_outs", 32'({miso_o, miso_oe_o, frame_done_o, frame_err_o, busy_o}), 32'd0);

    // Full frame with A5
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'hA5, 16, -1, 8'h00, rx);
    check("a5_word", rx, 32'h14A0);
    check("a5_done", 32'(done_cnt - d0), 32'd1);
    check("a5_err", 32'(err_cnt - e0), 32'd0);

    // Back-to-back 00 and FF
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'h00, 16, -1, 8'h00, rx);
    check("00_word", rx, 32'h0000);
    run_frame(8'hFF, 16, -1, 8'h00, rx);
    check("ff_word", rx, 32'h1FE0);
    check("b2b_done", 32'(done_cnt - d0), 32'd2);
    check("b2b_err", 32'(err_cnt - e0), 32'd0);

    // Short frame: 9 clocks then CS release
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'hA5, 9, -1, 8'h00, rx);
    check("short_bits", rx, 32'h029);
    check("short_err", 32'(err_cnt - e0), 32'd1);
    check("short_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    run_frame(8'h5A, 16, -1, 8'h00, rx);
    check("after_err_word", rx, 32'h0B40);
    check("after_err_done", 32'(done_cnt - d0), 32'd1);

    // Over-long frame: 20 clocks with 81
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'h81, 20, -1, 8'h00, rx);
    check("long_first16", 32'(rx[19:4]), 32'h1020);
    check("long_tail", 32'(rx[3:0]), 32'h0);
    check("long_done", 32'(done_cnt - d0), 32'd1);
    check("long_err", 32'(err_cnt - e0), 32'd0);

    // SCLK toggling while idle, then sample change mid-frame
    idle_act = 1'b0;
    track_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_i = 1'b0; wait_clk(20);
      sclk_i = 1'b1; wait_clk(20);
    end
    track_idle = 1'b0;
    check("idle_quiet", 32'(idle_act), 32'd0);
    run_frame(8'h3C, 16, 4, 8'hC3, rx);
    check("midchange_word", rx, 32'h0780);

    // Reset at SCLK cycle 6 with CS held low
    d0 = done_cnt; e0 = err_cnt;
    sample_i = 8'hA5;
    cs_i = 1'b0;
    wait_clk(20);
    for (int i = 0; i < 6; i++) begin
      sclk_i = 1'b0; wait_clk(50);
      sclk_i = 1'b1; wait_clk(50);
    end
    sclk_i = 1'b0;
    wait_clk(10);
    rst = 1'b0;
    #1;
    check("midreset_outs", 32'({miso_o, miso_oe_o, frame_done_o, frame_err_o, busy_o}), 32'd0);
    wait_clk(5);
    rst = 1'b1;
    idle_act = 1'b0;
    track_idle = 1'b1;
    wait_clk(20);
    for (int i = 0; i < 3; i++) begin
      sclk_i = 1'b1; wait_clk(50);
      sclk_i = 1'b0; wait_clk(50);
    end
    sclk_i = 1'b1;
    wait_clk(20);
    cs_i = 1'b1;
    wait_clk(20);
    track_idle = 1'b0;
    check("no_start_cs_low", 32'(idle_act), 32'd0);
    check("midreset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    run_frame(8'h96, 16, -1, 8'h00, rx);
    check("post_reset_word", rx, 32'h12C0);
    check("post_reset_done", 32'(done_cnt - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmod_als_spi_responder.md
Name: pmod_als_spi_responder

Overview:
- Synthesizable SPI responder that emulates the PMOD ALS light sensor (ADC081S021-style 16-bit read frame). It is the peripheral end of the SPI link driven by the team's ALS master (cs_o, sclk_o, bit_rx_i).
- Runs in the 100 MHz system domain and oversamples the master's CS and SCLK, then shifts an 8-bit light sample out on MISO.
- Used in board loopback tests and as a self-checking bench peer for the ALS master.

Parameters:
- DATA_W, 8, width of the emulated light sample.
- LEAD_ZEROS, 3, number of zero bits before the MSB of the sample.
- FRAME_BITS, 16, number of SCLK cycles in one full frame; bits after the sample are 0.
- SYNC_STAGES, 2, flip-flop stages on cs_i and sclk_i (minimum 2).

Ports:
- clk_100m_i  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- cs_i  in  1  chip select from master, active low.
- sclk_i  in  1  SPI clock from master; idle level is high or low, and only edges inside an active frame are used.
- sample_i  in  DATA_W  light value to report.
- miso_o  out  1  serial data to master (bit_rx_i of the master).
- miso_oe_o  out  1  1 while CS is active (tri-state enable for the pad).
- frame_done_o  out  1  one-cycle pulse when a complete frame ends.
- frame_err_o  out  1  one-cycle pulse when CS rises before FRAME_BITS rising SCLK edges.
- busy_o  out  1  1 while in the SHIFT state.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchronizers load cs=1, sclk=0;
  - state=IDLE, shift register=0, bit counter=0;
  - outputs: miso_o=0, miso_oe_o=0, frame_done_o=0, frame_err_o=0, busy_o=0.
- Synchronization:
  - cs_i and sclk_i pass through SYNC_STAGES flip-flops, then a registered edge detector produces cs_fall, cs_rise, sclk_rise and sclk_fall.
  - Latency from a pin edge to the resulting miso_o change is SYNC_STAGES+1 clk cycles (3 at default).
- Master timing requirement: the SCLK high and low phases are each at least 8 clk_100m_i cycles.
- Frame word, captured at cs_fall:
  - sample_i is latched;
  - word = {LEAD_ZEROS zeros, sample[DATA_W-1:0], zeros up to FRAME_BITS}, MSB first. At default this is sample<<5.
- State machine IDLE -> SHIFT:
  - Transition on cs_fall.
  - Load the word, set miso_o = word[FRAME_BITS-1] and miso_oe_o=1, clear the bit counter, set busy_o=1.
- SHIFT, SCLK falling edge:
  - Shift left with zero fill; miso_o takes the new MSB.
  - Falling edges before the first rising edge do not shift.
- SHIFT, SCLK rising edge:
  - The bit counter increments and saturates at FRAME_BITS.
  - After FRAME_BITS rising edges, miso_o stays 0 regardless of further SCLK edges.
- SHIFT -> IDLE on cs_rise:
  - Drop miso_oe_o and busy_o; set miso_o=0.
  - If count == FRAME_BITS, pulse frame_done_o; otherwise pulse frame_err_o. Pulses are exactly 1 cycle.
- In IDLE, SCLK edges are ignored and miso_oe_o stays 0.
- Simultaneous events (same cycle):
  - sclk_rise and cs_rise: the counter update is applied first, then completion is judged, so the 16th rise together with CS release counts as done.
  - cs_fall and sclk_fall: load takes priority and no shift occurs.
- sample_i changing mid-frame has no effect until the next cs_fall.
- Reset asserted mid-frame: immediate return to IDLE and reset values, with no done or err pulse. After release, CS still low does not start a frame; a fresh cs_fall is required.
- A glitch on cs_i shorter than SYNC_STAGES cycles may be missed; this is acceptable.

Test Plan:
- Reset with cs_i=1, then release. Then drive sample_i=8'hA5 and a 16-cycle, 1 MHz SCLK frame -> the master-side shift register reads 16'h14A0; frame_done_o pulses once; frame_err_o stays 0; miso_oe_o=1 only while cs_i=0.
- Run back-to-back frames with sample_i=8'h00, then 8'hFF -> reads 16'h0000, then 16'h1FE0; two done pulses.
- Release CS after 9 SCLK cycles -> frame_err_o pulses once, no done pulse, miso_oe_o=0 three cycles after cs_i rises, and the next full frame reads correctly.
- Apply 20 SCLK cycles in one frame with sample_i=8'h81 -> the first 16 bits read 16'h1020, bits 17-20 read 0, and frame_done_o pulses.
- Toggle SCLK while CS is high, then change sample_i from 8'h3C to 8'hC3 mid-frame -> no output activity while idle; the frame reads 16'h0780 (3C<<5).
- Assert rst at SCLK cycle 6 with CS held low -> outputs return to reset values immediately; no frame starts until CS goes high and then low again, and that frame reads correctly.
